matrix_column_scanner: RTL

//   Upstream driver for the irrigation-status LED matrix decoder.
//   - Rotates a one-hot column strobe C0..C4 at a programmable rate.
//   - Synchronises the raw irrigation-mode requests (aspersion / gotejamento).
//   - Latches the mode only at frame boundaries, so one 5-column frame never shows a mixed pattern.
//   - Outputs as/gt/C0..C4 feed the row decoder directly.

---
 rtl/matrix_column_scanner.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/matrix_column_scanner.sv
// Column strobe generator and frame-aligned irrigation-mode latch for the LED matrix decoder.
// Optional build macro MODE_DEBOUNCE_EN: mode changes need DEB_FRAMES identical frame-boundary samples.
module matrix_column_scanner #(
   parameter int SCAN_DIV   = 50000,
   parameter int DEB_FRAMES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic as_req,
   input  logic gt_req,
   output logic as,
   output logic gt,
   output logic C0,
   output logic C1,
   output logic C2,
   output logic C3,
   output logic C4,
   output logic frame_tick,
   output logic conflict
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   generate
      if ((SCAN_DIV < 2) || (DEB_FRAMES < 1)) begin : g_bad_params
         $error("matrix_column_scanner: SCAN_DIV must be >= 2 and DEB_FRAMES >= 1");
      end
   endgenerate

   // Two-flop synchronisers for the asynchronous mode requests
   logic as_meta_reg, as_s_reg;
   logic gt_meta_reg, gt_s_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         as_meta_reg <= 1'b0;
         as_s_reg    <= 1'b0;
         gt_meta_reg <= 1'b0;
         gt_s_reg    <= 1'b0;
      end else begin
         as_meta_reg <= as_req;
         as_s_reg    <= as_meta_reg;
         gt_meta_reg <= gt_req;
         gt_s_reg    <= gt_meta_reg;
      end
   end

   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       col_idx_reg;
   logic [4:0]       col_oh_reg;
   logic             tick_reg;
   logic             wrap;
   logic             boundary;

   assign wrap     = (cnt_reg == CNT_LAST);
   // The C4 -> C0 edge; col_oh_reg[4] is only set while scanning
   assign boundary = en && col_oh_reg[4] && wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg     <= '0;
         col_idx_reg <= 3'd0;
         col_oh_reg  <= 5'b00000;
         tick_reg    <= 1'b0;
      end else if (!en) begin
         cnt_reg     <= '0;
         col_idx_reg <= 3'd0;
         col_oh_reg  <= 5'b00000;
         tick_reg    <= 1'b0;
      end else if (col_oh_reg == 5'b00000) begin
         // Start-up: first enabled edge shows C0 for a full column period
         cnt_reg     <= '0;
         col_idx_reg <= 3'd0;
         col_oh_reg  <= 5'b00001;
         tick_reg    <= 1'b0;
      end else if (wrap) begin
         cnt_reg     <= '0;
         col_idx_reg <= (col_idx_reg == 3'd4) ? 3'd0 : col_idx_reg + 3'd1;
         col_oh_reg  <= {col_oh_reg[3:0], col_oh_reg[4]};
         tick_reg    <= col_oh_reg[4];
      end else begin
         cnt_reg     <= cnt_reg + 1'b1;
         tick_reg    <= 1'b0;
      end
   end

   logic as_reg, gt_reg, conflict_reg;

`ifdef MODE_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEB_FRAMES + 1);
   localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEB_FRAMES);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

   logic [1:0]       cand_reg;
   logic [DEB_W-1:0] stable_reg;
   logic [DEB_W-1:0] stable_next;

   // Count of consecutive boundaries showing the same candidate, saturating at DEB_FRAMES
   always_comb begin
      stable_next = DEB_ONE;
      if ((stable_reg != '0) && ({as_s_reg, gt_s_reg} == cand_reg)) begin
         stable_next = (stable_reg == DEB_FULL) ? DEB_FULL : stable_reg + DEB_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_reg     <= 2'b00;
         stable_reg   <= '0;
         as_reg       <= 1'b0;
         gt_reg       <= 1'b0;
         conflict_reg <= 1'b0;
      end else if (!en) begin
         cand_reg   <= 2'b00;
         stable_reg <= '0;
      end else if (boundary) begin
         cand_reg   <= {as_s_reg, gt_s_reg};
         stable_reg <= stable_next;
         if (stable_next == DEB_FULL) begin
            if (as_s_reg && gt_s_reg) begin
               conflict_reg <= 1'b1;
            end else begin
               as_reg       <= as_s_reg;
               gt_reg       <= gt_s_reg;
               conflict_reg <= 1'b0;
            end
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         as_reg       <= 1'b0;
         gt_reg       <= 1'b0;
         conflict_reg <= 1'b0;
      end else if (boundary) begin
         // Both requests at once: keep the displayed mode, flag the conflict
         if (as_s_reg && gt_s_reg) begin
            conflict_reg <= 1'b1;
         end else begin
            as_reg       <= as_s_reg;
            gt_reg       <= gt_s_reg;
            conflict_reg <= 1'b0;
         end
      end
   end
`endif

   assign as         = as_reg;
   assign gt         = gt_reg;
   assign conflict   = conflict_reg;
   assign frame_tick = tick_reg;
   assign C0         = col_oh_reg[0];
   assign C1         = col_oh_reg[1];
   assign C2         = col_oh_reg[2];
   assign C3         = col_oh_reg[3];
   assign C4         = col_oh_reg[4];

endmodule
